// File: rtl/fmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fmul_pipe
// Brief    : 3-stage IEEE-style FP multiplier, RNE rounding, valid/ready flow
// Revision : 1.0
// ============================================================================
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   ovf,
    output logic                   unf,
    output logic                   nv
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;

    localparam logic [EW-1:0] c_BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] c_EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic             r_v1, r_v2, r_v3;
    logic             r_s1, r_s2;
    logic [EW-1:0]    r_e1, r_e2;
    logic [PW-1:0]    r_p1;
    logic             r_nv1, r_inf1, r_zero1;
    logic             r_nv2, r_inf2, r_zero2;
    logic [MAN_W-1:0] r_frac2;
    logic             r_g2, r_st2;
    logic [W-1:0]     r_y;
    logic             r_ovf, r_unf, r_nv;

    logic w_en;

    // A stalled S3 freezes the whole pipe; bubbles advance like valid data.
    assign w_en     = ~r_v3 | out_ready;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // S1: unpack, classify, exponent sum, exact mantissa product
    // ------------------------------------------------------------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_zero_a, w_zero_b;
    logic             w_inf_a, w_inf_b;
    logic             w_nan_a, w_nan_b;
    logic [EW-1:0]    w_e_s1;
    logic [PW-1:0]    w_p_s1;

    assign w_sa = x1[W-1];
    assign w_sb = x2[W-1];
    assign w_ea = x1[W-2 -: EXP_W];
    assign w_eb = x2[W-2 -: EXP_W];
    assign w_ma = x1[MAN_W-1:0];
    assign w_mb = x2[MAN_W-1:0];

    // Subnormal inputs are flushed: any zero exponent counts as zero.
    assign w_zero_a = (w_ea == '0);
    assign w_zero_b = (w_eb == '0);
    assign w_inf_a  = (&w_ea) & (w_ma == '0);
    assign w_inf_b  = (&w_eb) & (w_mb == '0);
    assign w_nan_a  = (&w_ea) & (|w_ma);
    assign w_nan_b  = (&w_eb) & (|w_mb);

    assign w_e_s1 = {2'b00, w_ea} + {2'b00, w_eb} - c_BIAS;
    assign w_p_s1 = {{(MAN_W+1){1'b0}}, 1'b1, w_ma} * {{(MAN_W+1){1'b0}}, 1'b1, w_mb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_s1    <= 1'b0;
            r_e1    <= '0;
            r_p1    <= '0;
            r_nv1   <= 1'b0;
            r_inf1  <= 1'b0;
            r_zero1 <= 1'b0;
        end else if (w_en) begin
            r_v1    <= in_valid;
            r_s1    <= w_sa ^ w_sb;
            r_e1    <= w_e_s1;
            r_p1    <= w_p_s1;
            r_nv1   <= w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
            r_inf1  <= w_inf_a | w_inf_b;
            r_zero1 <= w_zero_a | w_zero_b;
        end
    end

    // ------------------------------------------------------------------
    // S2: normalise product into [1,2), extract guard and sticky
    // ------------------------------------------------------------------
    logic             w_msb;
    logic [MAN_W-1:0] w_frac_s2;
    logic             w_g_s2, w_st_s2;
    logic [EW-1:0]    w_e_s2;

    // Only the fraction below the hidden bit is carried forward.
    assign w_msb     = r_p1[PW-1];
    assign w_frac_s2 = w_msb ? r_p1[PW-2 -: MAN_W] : r_p1[PW-3 -: MAN_W];
    assign w_g_s2    = w_msb ? r_p1[MAN_W] : r_p1[MAN_W-1];
    assign w_st_s2   = w_msb ? (|r_p1[MAN_W-1:0]) : (|r_p1[MAN_W-2:0]);
    assign w_e_s2    = r_e1 + EW'(w_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_s2    <= 1'b0;
            r_e2    <= '0;
            r_frac2 <= '0;
            r_g2    <= 1'b0;
            r_st2   <= 1'b0;
            r_nv2   <= 1'b0;
            r_inf2  <= 1'b0;
            r_zero2 <= 1'b0;
        end else if (w_en) begin
            r_v2    <= r_v1;
            r_s2    <= r_s1;
            r_e2    <= w_e_s2;
            r_frac2 <= w_frac_s2;
            r_g2    <= w_g_s2;
            r_st2   <= w_st_s2;
            r_nv2   <= r_nv1;
            r_inf2  <= r_inf1;
            r_zero2 <= r_zero1;
        end
    end

    // ------------------------------------------------------------------
    // S3: round to nearest even, range check, special-value select
    // ------------------------------------------------------------------
    logic             w_inc;
    logic [MAN_W:0]   w_sum;
    logic             w_carry;
    logic [EW-1:0]    w_e_r;
    logic             w_e_big, w_e_low;
    logic [W-1:0]     w_y_s3;
    logic             w_ovf_s3, w_unf_s3, w_nv_s3;

    assign w_inc   = r_g2 & (r_st2 | r_frac2[0]);
    // Hidden bit is always one, so a fraction carry means the value reached 2.0
    // and the wrapped-to-zero fraction is already the correct mantissa.
    assign w_sum   = {1'b0, r_frac2} + (MAN_W+1)'(w_inc);
    assign w_carry = w_sum[MAN_W];
    assign w_e_r   = r_e2 + EW'(w_carry);
    assign w_e_big = ~w_e_r[EW-1] & (w_e_r >= c_EMAX);
    assign w_e_low = w_e_r[EW-1] | (w_e_r == '0);

    always_comb begin
        w_y_s3   = {r_s2, w_e_r[EXP_W-1:0], w_sum[MAN_W-1:0]};
        w_ovf_s3 = 1'b0;
        w_unf_s3 = 1'b0;
        w_nv_s3  = 1'b0;
        if (r_nv2) begin
            w_y_s3  = c_QNAN;
            w_nv_s3 = 1'b1;
        end else if (r_inf2) begin
            w_y_s3 = {r_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r_zero2) begin
            w_y_s3 = {r_s2, {(W-1){1'b0}}};
        end else if (w_e_big) begin
            w_y_s3   = {r_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf_s3 = 1'b1;
        end else if (w_e_low) begin
            w_y_s3   = {r_s2, {(W-1){1'b0}}};
            w_unf_s3 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3  <= 1'b0;
            r_y   <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_nv  <= 1'b0;
        end else if (w_en) begin
            r_v3  <= r_v2;
            r_y   <= w_y_s3;
            r_ovf <= w_ovf_s3;
            r_unf <= w_unf_s3;
            r_nv  <= w_nv_s3;
        end
    end

    assign out_valid = r_v3;
    assign y         = r_y;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign nv        = r_nv;

endmodule
`default_nettype wire

// File: doc/fmul_pipe.md
# fmul_pipe

Parametrised, pipelined floating-point multiplier with a valid/ready stream interface. It is the next generation of the team's single-precision multiplier and replaces the fixed two-stage, truncating design. New behaviour: configurable exponent/mantissa widths, round-to-nearest-even, IEEE special-value handling (inf/NaN/signed zero), exception flags, and back-pressure. It sits in the FPU datapath between the operand-issue logic and the result write-back arbiter.

## Interface
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 23, stored mantissa width (hidden bit not counted)
- W, derived, 1+EXP_W+MAN_W; total word width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset; clears all valid bits and flags
- in_valid  input  1  operand pair x1/x2 presented
- in_ready  output  1  pipeline can accept this cycle
- x1, x2  input  W  operands {sign, exp, man}
- out_valid  output  1  y and flags are valid
- out_ready  input  1  consumer accepts y
- y  output  W  product
- ovf, unf, nv  output  1 each  overflow, underflow (flush), invalid; qualified by out_valid

## Operation
- Three stages S1 (unpack + mantissa product), S2 (normalise), S3 (round + pack), each with its own valid bit v1..v3.
- Global enable en = !v3 | out_ready; every stage register loads only when en=1; in_ready = en; a transfer into S1 occurs on in_valid & en.
- S1 classification: exp==0 → zero (subnormal inputs flushed to zero); exp all-ones & man==0 → inf; exp all-ones & man!=0 → NaN.
- Sign s = s1 ^ s2 in all cases, including zero and inf results.
- S1 arithmetic: exponent e = e1 + e2 - BIAS in EXP_W+2 bits, signed; product P = {1,m1}*{1,m2}, 2*MAN_W+2 bits, exact.
- S2: if P MSB set, e += 1 and the mantissa window is P[2*MAN_W+1 -: MAN_W+1]; else window P[2*MAN_W -: MAN_W+1]. Guard = next bit below window; sticky = OR of all remaining lower bits.
- S3 rounding: RNE; increment when guard & (sticky | lsb). Rounding carry-out sets mantissa 0 and e += 1.
- S3 result selection, priority order:
  - any NaN operand, or inf × zero → canonical quiet NaN {0, all-ones, 1 followed by zeros}, nv=1
  - any inf operand → {s, all-ones, 0}
  - any zero operand → {s, 0, 0}
  - e ≥ 2^EXP_W - 1 after rounding → {s, all-ones, 0}, ovf=1
  - e ≤ 0 after rounding → {s, 0, 0}, unf=1 (no subnormal output)
  - else {s, e[EXP_W-1:0], rounded man}
- At most one flag is set per result; flags are per-result, not sticky.

## Timing
- Latency: 3 cycles from accepted input to out_valid when out_ready stays high; throughput 1 per cycle.
- Stall: while v3=1 and out_ready=0, all stages hold, in_ready=0, and y/flags stay stable.
- Bubbles are not collapsed: invalid stages advance with en like valid ones.
- Reset: out_valid=0, in_ready=1, ovf=unf=nv=0, y=0. Asserting rst_n mid-stream discards all in-flight operations; after release, the first accepted input appears 3 cycles later.
- Simultaneous out_ready and in_valid with v3=1: output retires and new input enters in the same cycle.
- in_valid & !in_ready: input is ignored; the producer must hold it.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2) → y=0x40400000 three cycles later, all flags 0; 0x3F800800 × 0x3F800800 → 0x3F801000 (tie with even LSB, rounds down).
- 0x3F800001 × 0x3FC00000 (tie with odd LSB) → 0x3FC00002; 0xBF800000 × 0x00000000 → 0x80000000 (signed zero).
- 0x7F000000 × 0x7F000000 → 0x7F800000, ovf=1; 0x00800000 × 0x00800000 → 0x00000000, unf=1.
- 0x7F800000 × 0x00000000 → 0x7FC00000, nv=1; 0xFF800000 × 0x40000000 → 0xFF800000, no flags; NaN 0x7F800001 × 1.0 → 0x7FC00000, nv=1.
- Back-pressure: stream 6 back-to-back operands with out_ready held low for cycles 3-7 → in_ready drops while v3 is held, all 6 results delivered in order, none lost or duplicated, y stable during the stall.
- Reset: assert rst_n low with 3 operations in flight → out_valid=0 immediately, no stale result after release; EXP_W=5/MAN_W=10 instance: 0x3E00 × 0x4000 → 0x4200.
